// File: rtl/fpu_pkg.sv
// Shared types and constants for the shared-FPU scheduler.
//   status_t      : 2-bit FPU result status
//   sched_state_t : scheduler FSM encoding
//   field helpers : sign/exponent/mantissa extraction for the 32-bit custom float
package fpu_pkg;

  typedef enum logic [1:0] {
    OVERFLOW  = 2'd0,
    UNDERFLOW = 2'd1,
    EXACT     = 2'd2,
    INEXACT   = 2'd3
  } status_t;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 21;
  localparam int unsigned MANT_MSB = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } sched_state_t;

  function automatic logic fp_sign(input logic [31:0] w);
    return w[SIGN_BIT];
  endfunction

  function automatic logic [EXP_MSB-EXP_LSB:0] fp_exp(input logic [31:0] w);
    return w[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [MANT_MSB:0] fp_mant(input logic [31:0] w);
    return w[MANT_MSB:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   rr_ptr    : highest-priority index for this scan
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted bit
//   any_req   : at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    int unsigned w_idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    w_idx     = 0;
    // Scan from rr_ptr upward; wrap with a subtract rather than a modulo
    // since rr_ptr + k never reaches 2*NREQ.
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!any_req && req[w_idx]) begin
        any_req      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fpu_share_scheduler.sv
// Shares one handshake-less FPU among NREQ requesters.
// Grants round-robin, holds operands for FPU_LATENCY cycles, samples the
// FPU result at the end of that window and returns it with valid/ready.
//   clock_100Khz, reset(async, active-low)
//   req_valid/req_op_a/req_op_b/req_ready    : request side
//   resp_valid/resp_ready/resp_data/resp_status : response side
//   fpu_op_a/fpu_op_b -> FPU, fpu_data_in/fpu_status_in <- FPU
//   busy, grant_id : status
module fpu_share_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned FPU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                      clock_100Khz,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*32-1:0]        req_op_a,
  input  logic [NREQ*32-1:0]        req_op_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [31:0]               resp_data,
  output status_t                   resp_status,
  output logic [31:0]               fpu_op_a,
  output logic [31:0]               fpu_op_b,
  input  logic [31:0]               fpu_data_in,
  input  status_t                   fpu_status_in,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_counter;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_id;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [31:0]      r_resp_data;
  status_t          r_resp_status;

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_req   (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready   = w_grant;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_counter == '0) w_state_nxt = RESPOND;
      end
      RESPOND: begin
        resp_valid[r_grant_id] = 1'b1;
        if (resp_ready[r_grant_id]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_counter     <= '0;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_resp_data   <= '0;
      r_resp_status <= EXACT;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a     <= req_op_a[int'(w_grant_idx)*32 +: 32];
            r_op_b     <= req_op_b[int'(w_grant_idx)*32 +: 32];
            r_grant_id <= w_grant_idx;
            r_counter  <= CNT_W'(FPU_LATENCY - 1);
            r_rr_ptr   <= (w_grant_idx == IDX_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
          end
        end
        WAIT: begin
          if (r_counter == '0) begin
            r_resp_data   <= fpu_data_in;
            r_resp_status <= fpu_status_in;
          end else begin
            r_counter <= r_counter - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fpu_op_a    = r_op_a;
  assign fpu_op_b    = r_op_b;
  assign resp_data   = r_resp_data;
  assign resp_status = r_resp_status;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_share_scheduler.sv
module tb_fpu_share_scheduler;
  import fpu_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned LAT   = 32;
  localparam int unsigned CNT_W = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_op_a;
  logic [NREQ*32-1:0]  req_op_b;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [31:0]         resp_data;
  status_t             resp_status;
  logic [31:0]         fpu_op_a;
  logic [31:0]         fpu_op_b;
  logic [31:0]         fpu_data_in;
  status_t             fpu_status_in;
  logic                busy;
  logic [1:0]          grant_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int since  = 0;

  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];

  logic        stub_force;
  logic [31:0] stub_data;
  status_t     stub_stat;

  typedef struct {
    int          idx;
    logic [31:0] data;
    status_t     st;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  fpu_share_scheduler #(
    .NREQ        (NREQ),
    .FPU_LATENCY (LAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock_100Khz  (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_status   (resp_status),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_op_a = '0;
    req_op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op_a[i*32 +: 32] = opa[i];
      req_op_b[i*32 +: 32] = opb[i];
    end
  end

  // Stub FPU: the result is only correct once operands have been held for
  // LAT cycles after an accept; before that it outputs a moving garbage word.
  always @(posedge clk or negedge reset) begin
    if (!reset)                  since <= 0;
    else if (req_ready != '0)    since <= 1;
    else if (since < 1000)       since <= since + 1;
  end

  always_comb begin
    if (since >= int'(LAT)) begin
      fpu_data_in   = stub_force ? stub_data : (fpu_op_a + fpu_op_b);
      fpu_status_in = stub_force ? stub_stat : EXACT;
    end else begin
      fpu_data_in   = 32'hBAD0_0000 ^ 32'(since);
      fpu_status_in = INEXACT;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each completed response handshake.
  always @(negedge clk) begin
    if (reset === 1'b1 && (resp_valid & resp_ready) != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_onehot", 32'(resp_valid), 32'(1) << mon_e.idx);
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_status", 32'(resp_status), 32'(mon_e.st));
      end
    end
  end

  task automatic push_exp(input int idx, input logic [31:0] d, input status_t s);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.st   = s;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int n);
    n = 0;
    while (req_ready == '0 && n < 200) begin
      step(1);
      n++;
    end
    chk("accept_seen", 32'(req_ready != '0), 32'h1);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid == '0 && n < 200) begin
      step(1);
      n++;
    end
    chk("resp_seen", 32'(resp_valid != '0), 32'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    chk("idle_seen", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;
    int g;

    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    stub_force = 1'b0;
    stub_data  = '0;
    stub_stat  = EXACT;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    step(3);

    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_status", 32'(resp_status), 32'(EXACT));
    chk("rst_fpu_op_a", fpu_op_a, 32'h0);
    chk("rst_fpu_op_b", fpu_op_b, 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    reset = 1'b1;
    step(1);

    // Single request, forced stub result
    opa[1] = 32'h3FE0_0000;
    opb[1] = 32'h3FE0_0000;
    stub_force = 1'b1;
    stub_data  = 32'h4000_0000;
    stub_stat  = EXACT;
    resp_ready = '1;
    req_valid  = 4'b0010;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h2);
    push_exp(1, 32'h4000_0000, EXACT);
    step(1);
    req_valid = '0;
    #1;
    chk("t1_fpu_op_a", fpu_op_a, 32'h3FE0_0000);
    chk("t1_fpu_op_b", fpu_op_b, 32'h3FE0_0000);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_grant_id", 32'(grant_id), 32'h1);
    wait_resp(n);
    chk("t1_resp_cycle", 32'(n + 1), 32'd33);
    chk("t1_op_held", fpu_op_a, 32'h3FE0_0000);
    step(1);
    chk("t1_back_idle", 32'(busy), 32'h0);
    chk("t1_op_kept", fpu_op_a, 32'h3FE0_0000);
    stub_force = 1'b0;

    // Round-robin with all requesters active
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 32'h1111_0000 * 32'(i + 1);
      opb[i] = 32'h0000_0123 << i;
    end
    req_valid  = '1;
    resp_ready = '1;
    #1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      wait_accept(n);
      chk("t2_grant", 32'(req_ready), 32'(1) << g);
      if (k > 0) chk("t2_spacing", 32'(cyc - prev), 32'd34);
      prev = cyc;
      push_exp(g, opa[g] + opb[g], EXACT);
      step(1);
    end
    req_valid = '0;
    wait_idle();
    chk("t2_sb_drained", 32'(sb.size()), 32'h0);

    // Response back-pressure on requester 0 while requester 1 waits
    do_reset();
    resp_ready = '0;
    req_valid  = 4'b0011;
    #1;
    chk("t3_req_ready", 32'(req_ready), 32'h1);
    push_exp(0, opa[0] + opb[0], EXACT);
    step(1);
    req_valid = 4'b0010;
    wait_resp(n);
    for (int j = 0; j < 10; j++) begin
      chk("t3_hold_valid", 32'(resp_valid), 32'h1);
      chk("t3_hold_data", resp_data, opa[0] + opb[0]);
      chk("t3_no_accept", 32'(req_ready), 32'h0);
      step(1);
    end
    resp_ready = 4'b0001;
    #1;
    chk("t3_no_accept_respond", 32'(req_ready), 32'h0);
    step(1);
    chk("t3_idle_after", 32'(busy), 32'h0);
    chk("t3_req1_granted", 32'(req_ready), 32'h2);
    push_exp(1, opa[1] + opb[1], EXACT);
    resp_ready = '1;
    step(1);
    req_valid = '0;
    wait_idle();

    // Reset in the middle of WAIT
    req_valid = 4'b0001;
    #1;
    chk("t4_req_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = '0;
    step(14);
    reset = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("t4_rst_fpu_op_a", fpu_op_a, 32'h0);
    chk("t4_rst_grant_id", 32'(grant_id), 32'h0);
    step(2);
    reset = 1'b1;
    step(1);
    req_valid = 4'b0101;
    #1;
    chk("t4_rrptr_zero", 32'(req_ready), 32'h1);
    push_exp(0, opa[0] + opb[0], EXACT);
    step(1);
    req_valid = '0;
    wait_idle();
    req_valid = 4'b0100;
    #1;
    chk("t4_req2_granted", 32'(req_ready), 32'h4);
    push_exp(2, opa[2] + opb[2], EXACT);
    step(1);
    req_valid = '0;
    wait_resp(n);
    chk("t4_full_latency", 32'(n + 1), 32'd33);
    wait_idle();

    // Status passthrough
    stub_force = 1'b1;
    stub_data  = 32'h7FE0_0000;
    stub_stat  = OVERFLOW;
    req_valid  = 4'b1000;
    #1;
    push_exp(3, 32'h7FE0_0000, OVERFLOW);
    step(1);
    req_valid = '0;
    wait_idle();
    stub_data = 32'h0000_0000;
    stub_stat = UNDERFLOW;
    req_valid = 4'b0100;
    #1;
    push_exp(2, 32'h0000_0000, UNDERFLOW);
    step(1);
    req_valid = '0;
    wait_idle();
    stub_force = 1'b0;

    // Late arrival during WAIT
    req_valid = 4'b0010;
    #1;
    chk("t6_req1", 32'(req_ready), 32'h2);
    push_exp(1, opa[1] + opb[1], EXACT);
    step(1);
    req_valid = '0;
    step(5);
    req_valid = 4'b1000;
    #1;
    chk("t6_wait_no_accept", 32'(req_ready), 32'h0);
    wait_resp(n);
    chk("t6_respond_no_accept", 32'(req_ready), 32'h0);
    step(1);
    chk("t6_req3_granted", 32'(req_ready), 32'h8);
    push_exp(3, opa[3] + opb[3], EXACT);
    step(1);
    req_valid = '0;
    wait_idle();

    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_share_scheduler.md
Name: fpu_share_scheduler

Overview:
- Shares one FPU datapath (32-bit custom float: sign [31], exponent [30:21], mantissa [20:0]) between NREQ requesters.
- The FPU has no start or done handshake. This block therefore:
  - arbitrates round-robin among requesters,
  - drives the FPU operand inputs stable for a fixed FPU_LATENCY window,
  - samples the FPU result and status at the end of that window,
  - returns the response to the granted requester with a valid/ready handshake.
- Sits between the requester fabric and the FPU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FPU_LATENCY, 32, cycles operands are held before result sampling. Covers FPU worst case: decode, align, operate, 22 normalize, writeback, output register lag.
- CNT_W, 6, width of the latency counter; must satisfy 2^CNT_W > FPU_LATENCY.

Ports:
- clock_100Khz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op_a  in  NREQ*32  flattened operand A; requester i uses bits [32i+31:32i].
- req_op_b  in  NREQ*32  flattened operand B, same packing as req_op_a.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  NREQ  one-hot response valid.
- resp_ready  in  NREQ  per-requester response ready; only the granted bit is examined.
- resp_data  out  32  result word.
- resp_status  out  2  status_t of the result.
- fpu_op_a  out  32  to FPU Op_A_in.
- fpu_op_b  out  32  to FPU Op_B_in.
- fpu_data_in  in  32  from FPU data_out.
- fpu_status_in  in  2  from FPU status_out.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NREQ)  index of the current or last grantee.

Behaviour:
- Clock and reset: one clock, clock_100Khz. Reset is asynchronous and active-low (reset=0 clears all state immediately).
- Reset values:
  - state=IDLE
  - req_ready=0, resp_valid=0
  - resp_data=0, resp_status=EXACT
  - fpu_op_a=0, fpu_op_b=0
  - grant_id=0, counter=0
  - rr_ptr=0 (highest-priority index)
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high, select the first set bit scanning from rr_ptr upward, with wrap.
  - req_ready[g] is asserted combinationally in the same cycle.
  - At the clock edge:
    - latch req_op_a/req_op_b[g] into fpu_op_a/fpu_op_b;
    - grant_id<=g;
    - counter<=FPU_LATENCY-1;
    - rr_ptr<=(g+1) mod NREQ;
    - go to WAIT.
  - With no request, stay in IDLE; req_ready=0.
- WAIT:
  - fpu_op_a/fpu_op_b are held constant.
  - counter decrements each cycle.
  - In the cycle counter==0: capture resp_data<=fpu_data_in and resp_status<=fpu_status_in, then go to RESPOND.
  - WAIT lasts exactly FPU_LATENCY cycles.
- RESPOND:
  - resp_valid[grant_id]=1; all other bits 0.
  - resp_data and resp_status are held.
  - When resp_ready[grant_id]=1, the handshake completes in that cycle; return to IDLE.
  - resp_valid deasserts in the next cycle.
  - No new grant is issued in the RESPOND cycle, so the minimum spacing between accepts is FPU_LATENCY+2 cycles.
- Latency: request accepted in cycle T → resp_valid high from cycle T+1+FPU_LATENCY.
- Operand holding: fpu_op_a/fpu_op_b keep the last issued operands after completion. They are never driven from unaccepted requests.
- Requester protocol:
  - A requester holds req_valid and its operands until it sees req_ready.
  - Dropping req_valid before acceptance is legal; the request is simply not seen.
  - req_valid rising during WAIT or RESPOND is queued implicitly and considered in the next IDLE.
- Simultaneous events:
  - Several requests in one IDLE cycle: only one is granted, chosen by round-robin.
  - The granted requester re-requesting immediately gets the lowest priority next round.
- Reset mid-operation: state returns to IDLE immediately and any in-flight result is discarded. The grantee sees no resp_valid and must reissue.
- Arithmetic: grant scan index uses modulo-NREQ wrap. counter is unsigned CNT_W bits and never underflows, because it is reloaded on accept.

Decomposition:
- Package fpu_pkg holds:
  - status_t (OVERFLOW, UNDERFLOW, EXACT, INEXACT; 2-bit);
  - field constants SIGN_BIT=31, EXP_MSB=30, EXP_LSB=21, MANT_MSB=20;
  - sched_state_t (IDLE, WAIT, RESPOND).
- One sub-module, rr_arbiter:
  - parameter NREQ;
  - inputs req and rr_ptr;
  - outputs one-hot grant plus grant index and any flag;
  - purely combinational.
- The FSM, counter and registers stay in fpu_share_scheduler.

Test Plan:
- Single request: NREQ=4, FPU_LATENCY=32; req_valid=4'b0010, op_a=0x3FE00000, op_b=0x3FE00000; stub FPU returns 0x40000000/EXACT.
  → req_ready=4'b0010 at cycle 0; fpu_op_a=0x3FE00000 from cycle 1; resp_valid=4'b0010 at cycle 33; resp_data=0x40000000; resp_status=EXACT.
- Round-robin: req_valid=4'b1111 held, resp_ready=4'b1111.
  → grant order 0,1,2,3,0; accepts spaced exactly 34 cycles apart.
- Response back-pressure: resp_ready[0]=0 for 10 cycles after resp_valid.
  → resp_valid[0] and resp_data stable for 10 cycles; req_ready stays 0 for req 1 throughout; return to IDLE one cycle after resp_ready[0]=1.
- Reset mid-WAIT: assert reset=0 at cycle 15 of WAIT.
  → busy=0, resp_valid=0, fpu_op_a=0, rr_ptr=0 immediately; after release, req_valid=4'b0100 is granted with the full 32-cycle latency.
- Status passthrough: stub FPU returns 0x7FE00000/OVERFLOW, then 0x00000000/UNDERFLOW.
  → resp_status=OVERFLOW, then UNDERFLOW, on the respective responses.
- Late arrival: req 3 asserts valid during WAIT of req 1.
  → req 3 is granted in the first IDLE cycle after req 1's handshake.
